// File: rtl/calc_mul_sched.sv
// calc_mul_sched: two-lane round-robin front end for the shared 16x16 multiplier (S1 operands -> S2 product).
// Optional performance counters are built only when CALC_MUL_SCHED_PERF_EN is defined.
module calc_mul_sched #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [31:0]        req_a,
  input  logic [31:0]        req_b,
  input  logic [5:0]         req_m,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  input  logic               perf_clr,
  output logic [CNT_W-1:0]   perf_busy,
  output logic [CNT_W-1:0]   perf_conf,
  output logic [CNT_W-1:0]   perf_stall
);

  // Radix-4 Booth product of two signed 16-bit operands, kept mod 2^32.
  function automatic logic [31:0] booth_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] acc;
    logic signed [31:0] ma;
    logic [16:0]        bx;
    acc = '0;
    ma  = {{16{a[15]}}, a};
    bx  = {b, 1'b0};
    for (int i = 0; i < 8; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: acc = acc + (ma <<< (2*i));
        3'b011:         acc = acc + (ma <<< (2*i + 1));
        3'b100:         acc = acc - (ma <<< (2*i + 1));
        3'b101, 3'b110: acc = acc - (ma <<< (2*i));
        default:        acc = acc;
      endcase
    end
    return acc;
  endfunction

  // Unsigned operands: a set MSB means the true value is 2^16 larger, so add the other operand << 16.
  function automatic logic [31:0] mul_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] m);
    logic [31:0] p;
    p = booth_mul(a, b);
    if (m[1] && a[15]) p = p + {b, 16'h0000};
    if (m[0] && b[15]) p = p + {a, 16'h0000};
    return m[2] ? {16'h0000, p[31:16]} : p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             vld_p1, own_p1;
  logic [15:0]      a_p1, b_p1;
  logic [2:0]       m_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             vld_p2, own_p2;
  logic [31:0]      data_p2;
  logic [TAG_W-1:0] tag_p2;
  logic             last_own;
  logic             adv2, s2_free, s1_free, accept, sel;
  logic [1:0]       grant;
  logic [31:0]      mul_out;

  assign adv2    = vld_p2 & rsp_ready[own_p2];
  assign s2_free = !vld_p2 | adv2;
  assign s1_free = !vld_p1 | s2_free;

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_own ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = rst ? 2'b00 : (grant & {2{s1_free}});
  assign accept    = |req_ready;
  assign sel       = req_ready[1];

  // ---- S0 -> S1: operand capture on accept ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      own_p1   <= 1'b0;
      last_own <= 1'b1;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      own_p1   <= sel;
      last_own <= sel;
    end else if (s2_free) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1   <= sel ? req_a[31:16] : req_a[15:0];
      b_p1   <= sel ? req_b[31:16] : req_b[15:0];
      m_p1   <= sel ? req_m[5:3]   : req_m[2:0];
      tag_p1 <= sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    end
  end

  assign mul_out = vld_p1 ? mul_result(a_p1, b_p1, m_p1) : 32'h0;

  // ---- S1 -> S2: product register, held under response backpressure ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      own_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
    end else if (vld_p1 && s2_free) begin
      vld_p2  <= 1'b1;
      own_p2  <= own_p1;
      data_p2 <= mul_out;
      tag_p2  <= tag_p1;
    end else if (adv2) begin
      vld_p2  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p2 ? (own_p2 ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = data_p2;
  assign rsp_tag   = tag_p2;

`ifdef CALC_MUL_SCHED_PERF_EN
  logic [CNT_W-1:0] busy_q, conf_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      conf_q  <= '0;
      stall_q <= '0;
    end else if (perf_clr) begin
      busy_q  <= '0;
      conf_q  <= '0;
      stall_q <= '0;
    end else begin
      if (vld_p1)           busy_q  <= sat_inc(busy_q);
      if (&req_valid)       conf_q  <= sat_inc(conf_q);
      if (vld_p2 && !adv2)  stall_q <= sat_inc(stall_q);
    end
  end

  assign perf_busy  = busy_q;
  assign perf_conf  = conf_q;
  assign perf_stall = stall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_busy  = '0;
  assign perf_conf  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_calc_mul_sched.sv
// Scoreboard bench for calc_mul_sched: queued expectations from an integer-arithmetic model, checked by a monitor.
// Counter expectations follow CALC_MUL_SCHED_PERF_EN (CNT_W=4 here so saturation is reachable).
module tb_calc_mul_sched;
  localparam int CW = 4;

  logic          clk, rst;
  logic [1:0]    req_valid, req_ready;
  logic [31:0]   req_a, req_b;
  logic [5:0]    req_m;
  logic [7:0]    req_tag;
  logic [1:0]    rsp_valid, rsp_ready;
  logic [31:0]   rsp_data;
  logic [3:0]    rsp_tag;
  logic          perf_clr;
  logic [CW-1:0] perf_busy, perf_conf, perf_stall;

  calc_mul_sched #(.TAG_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_m(req_m), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .perf_clr(perf_clr), .perf_busy(perf_busy), .perf_conf(perf_conf), .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lane;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cnt_conf = 0;
  int cnt_stall = 0;
  logic last_lane = 1'b1;
  logic hold = 1'b0;
  logic [1:0]  hv;
  logic [31:0] hd;
  logic [3:0]  ht;

  task automatic chk(string n, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, expv, $time);
    end
  endtask

  // Reference: extend each operand per its signedness, multiply exactly, keep the requested 32 bits.
  function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, logic [2:0] m);
    longint va, vb, p;
    va = m[1] ? longint'(a) : longint'($signed(a));
    vb = m[0] ? longint'(b) : longint'($signed(b));
    p  = va * vb;
    return m[2] ? {16'h0000, p[31:16]} : p[31:0];
  endfunction

  function automatic int sat(int v);
    return (v > 2**CW - 1) ? 2**CW - 1 : v;
  endfunction

  function automatic logic [CW-1:0] pexp(int v);
`ifdef CALC_MUL_SCHED_PERF_EN
    return CW'(sat(v));
`else
    return (v == v) ? '0 : '0;
`endif
  endfunction

  // Monitor / scoreboard: everything here is sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
      last_lane = 1'b1;
      cnt_conf = 0;
      cnt_stall = 0;
    end else begin
      logic [1:0] acc;
      logic l, own;
      exp_t e;
      chk("ready_not_both", (req_ready == 2'b11), 0);
      chk("ready_implies_valid", (req_ready & ~req_valid), 0);
      if (hold) begin
        chk("rsp_held_valid", rsp_valid, hv);
        chk("rsp_held_data", rsp_data, hd);
        chk("rsp_held_tag", rsp_tag, ht);
      end
      hold = 1'b0;
      if (rsp_valid != 2'b00) begin
        chk("rsp_onehot", $onehot(rsp_valid), 1);
        own = rsp_valid[1];
        if (rsp_ready[own]) begin
          chk("rsp_expected", (q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_lane", own, e.lane);
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_data", rsp_data, e.data);
          end
        end else begin
          hold = 1'b1; hv = rsp_valid; hd = rsp_data; ht = rsp_tag;
        end
      end
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        l = acc[1];
        if (req_valid == 2'b11) chk("rr_alternate", l, !last_lane);
        last_lane = l;
        e.lane = l;
        e.tag  = req_tag[l*4 +: 4];
        e.data = ref_mul(req_a[l*16 +: 16], req_b[l*16 +: 16], req_m[l*3 +: 3]);
        q.push_back(e);
      end
      if (perf_clr) begin
        cnt_conf = 0;
        cnt_stall = 0;
      end else begin
        if (req_valid == 2'b11) cnt_conf++;
        if (rsp_valid != 2'b00 && !rsp_ready[rsp_valid[1]]) cnt_stall++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int l, logic [15:0] a, logic [15:0] b, logic [2:0] m, logic [3:0] t);
    req_a[l*16 +: 16] = a;
    req_b[l*16 +: 16] = b;
    req_m[l*3 +: 3]   = m;
    req_tag[l*4 +: 4] = t;
  endtask

  task automatic rand_lane(int l);
    set_lane(l, 16'($urandom), 16'($urandom), 3'($urandom), 4'($urandom));
  endtask

  task automatic single(int l, logic [15:0] a, logic [15:0] b, logic [2:0] m, logic [3:0] t,
                        logic [31:0] expd);
    logic [1:0] bit_l;
    bit_l = (l == 1) ? 2'b10 : 2'b01;
    tick();
    set_lane(l, a, b, m, t);
    req_valid = bit_l;
    @(negedge clk);
    chk("single_ready", req_ready, bit_l);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_latency_gap", rsp_valid, 2'b00);
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, bit_l);
    chk("single_rsp_data", rsp_data, expd);
    chk("single_rsp_tag", rsp_tag, t);
  endtask

  task automatic drain(int n);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int i = 0; i < n && q.size() != 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic clear_perf();
    tick(); perf_clr = 1'b1;
    tick(); perf_clr = 1'b0;
    #1;
    chk("perf_busy_clr", perf_busy, pexp(0));
    chk("perf_conf_clr", perf_conf, pexp(0));
    chk("perf_stall_clr", perf_stall, pexp(0));
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_m = '0; req_tag = '0;
    rsp_ready = '0; perf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b11;
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_tag", rsp_tag, 4'h0);
    chk("reset_perf_busy", perf_busy, pexp(0));
    tick();
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;

    // Directed arithmetic with exact latency
    single(0, 16'd3,    16'hFFFE, 3'b000, 4'h1, 32'hFFFFFFFA);
    single(1, 16'hFFFF, 16'hFFFF, 3'b111, 4'h2, 32'h0000FFFE);
    single(1, 16'hFFFF, 16'hFFFF, 3'b100, 4'h3, 32'h00000000);
    single(1, 16'hFFFF, 16'hFFFF, 3'b011, 4'h4, 32'hFFFE0001);
    single(0, 16'h8000, 16'h8000, 3'b000, 4'h5, 32'h40000000);
    single(0, 16'h8000, 16'h7FFF, 3'b010, 4'h6, 32'h3FFF8000);
    drain(10);

    // Both lanes every cycle, full flow
    clear_perf();
    for (int i = 0; i < 12; i++) begin
      tick();
      rand_lane(0); rand_lane(1);
      req_valid = 2'b11;
      @(negedge clk);
      chk("both_lane_throughput", (req_ready != 2'b00), 1);
    end
    tick(); req_valid = 2'b00;
    #1;
    chk("perf_conf_stream", perf_conf, pexp(12));
    drain(10);

    // Response backpressure on lane 0
    clear_perf();
    tick();
    set_lane(0, 16'h1234, 16'h0056, 3'b000, 4'h7);
    req_valid = 2'b01; rsp_ready = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (rsp_valid != 2'b00);
    end
    chk("bp_rsp_arrives", seen, 1);
    chk("bp_ready_blocked", req_ready, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      rsp_ready = 2'b10;
      @(negedge clk);
      chk("bp_ready_blocked_hold", req_ready, 2'b00);
    end
    tick(); rsp_ready = 2'b01;
    #1;
    chk("perf_stall_5", perf_stall, pexp(5));
    repeat (3) tick();
    drain(10);

    // Busy saturation and clear
    clear_perf();
    tick(); req_valid = 2'b01;
    repeat (20) begin tick(); rand_lane(0); end
    req_valid = 2'b00;
    #1;
    chk("perf_busy_sat", perf_busy, pexp(20));
    clear_perf();
    drain(10);

    // Random traffic with random response backpressure
    clear_perf();
    for (int i = 0; i < 400; i++) begin
      tick();
      rand_lane(0); rand_lane(1);
      req_valid = 2'($urandom);
      rsp_ready = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
    end
    #1;
    chk("perf_conf_random", perf_conf, pexp(cnt_conf));
    chk("perf_stall_random", perf_stall, pexp(cnt_stall));
    drain(40);
    chk("random_drained", q.size(), 0);

    // Asynchronous reset with both stages occupied
    tick(); rand_lane(0); req_valid = 2'b01; rsp_ready = 2'b00;
    tick(); tick();
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 2'b00);
    chk("async_rst_req_ready", req_ready, 2'b00);
    chk("async_rst_rsp_data", rsp_data, 32'h0);
    tick(); tick();
    rst = 1'b0; rand_lane(0); rand_lane(1); req_valid = 2'b11; rsp_ready = 2'b11;
    @(negedge clk);
    chk("post_rst_lane0_first", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    drain(20);
    chk("final_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
